// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse_meter block: FSM state encoding and the
// default counter width.
package pulse_meter_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous 1-bit waveform, followed by a
// one-cycle delay register used for edge detection.
//
// Ports:
//   clock_i  - sole clock
//   reset_i  - asynchronous active-high reset, clears all flops
//   signal_i - raw waveform, may be asynchronous to clock_i
//   level_o  - synchronized level (second synchronizer stage)
//   rise_o   - level_o went 0 -> 1 relative to the previous cycle
//   fall_o   - level_o went 1 -> 0 relative to the previous cycle
module edge_sync (
  input  logic clock_i,
  input  logic reset_i,
  input  logic signal_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s0_q, s1_q, prev_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s0_q   <= signal_i;
      s1_q   <= s0_q;
      prev_q <= s1_q;
    end
  end

  assign level_o = s1_q;
  assign rise_o  = s1_q & ~prev_q;
  assign fall_o  = ~s1_q & prev_q;

endmodule

// File: rtl/pulse_meter.sv
// Pulse-train analyser: measures high width, low width and period of a 1-bit
// waveform in clock cycles, one report per complete rise-to-rise period.
//
// Ports:
//   clock_i  - sole clock
//   reset_i  - asynchronous active-high reset, clears all state and outputs
//   signal_i - measured waveform (synchronized internally)
//   high_w_o - high cycles of the last completed period (saturating)
//   low_w_o  - low cycles of the last completed period (saturating)
//   period_o - high_w_o + low_w_o, one bit wider so it never truncates
//   valid_o  - one-cycle strobe, outputs above updated in the same cycle
//   sat_o    - last reported period had a saturated high or low count
//   busy_o   - a measurement is in flight (HIGH or LOW state)
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             signal_i,
  output logic [WIDTH-1:0] high_w_o,
  output logic [WIDTH-1:0] low_w_o,
  output logic [WIDTH:0]   period_o,
  output logic             valid_o,
  output logic             sat_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] CntMax = '1;
  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  logic level, rise, fall;

  edge_sync u_edge_sync (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .signal_i (signal_i),
    .level_o  (level),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcap_q, hcap_d;
  logic             hsat_q, hsat_d;
  logic             lsat_q, lsat_d;
  logic [WIDTH-1:0] high_w_q, high_w_d;
  logic [WIDTH-1:0] low_w_q, low_w_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             valid_q, valid_d;
  logic             sat_q, sat_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcap_d   = hcap_q;
    hsat_d   = hsat_q;
    lsat_d   = lsat_q;
    high_w_d = high_w_q;
    low_w_d  = low_w_q;
    period_d = period_q;
    valid_d  = 1'b0;
    sat_d    = sat_q;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          cnt_d   = CntOne;
          hsat_d  = 1'b0;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (fall) begin
          hcap_d  = cnt_q;
          cnt_d   = CntOne;
          lsat_d  = 1'b0;
          state_d = StLow;
        end else if (level) begin
          if (cnt_q == CntMax) hsat_d = 1'b1;
          else                 cnt_d  = cnt_q + CntOne;
        end
      end
      StLow: begin
        if (rise) begin
          // Close the period and open the next high phase on the same edge.
          high_w_d = hcap_q;
          low_w_d  = cnt_q;
          period_d = (WIDTH+1)'(hcap_q) + (WIDTH+1)'(cnt_q);
          sat_d    = hsat_q | lsat_q;
          valid_d  = 1'b1;
          cnt_d    = CntOne;
          hsat_d   = 1'b0;
          state_d  = StHigh;
        end else if (!level) begin
          if (cnt_q == CntMax) lsat_d = 1'b1;
          else                 cnt_d  = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hcap_q   <= '0;
      hsat_q   <= 1'b0;
      lsat_q   <= 1'b0;
      high_w_q <= '0;
      low_w_q  <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcap_q   <= hcap_d;
      hsat_q   <= hsat_d;
      lsat_q   <= lsat_d;
      high_w_q <= high_w_d;
      low_w_q  <= low_w_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
    end
  end

  assign high_w_o = high_w_q;
  assign low_w_o  = low_w_q;
  assign period_o = period_q;
  assign valid_o  = valid_q;
  assign sat_o    = sat_q;
  assign busy_o   = (state_q != StIdle);

endmodule
